// File: rtl/stp_rx_pkg.sv
// Shared types and constants for the 4-bit serial receive controller.
// Optional parity support: define STP_RX_PARITY_EN.
package stp_rx_pkg;

  localparam int NUM_DATA_BITS = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 10;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
`ifdef STP_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/stp_rx_ctrl_if.sv
// Serial line, shifter and consumer signals of the receive controller.
// Carries parity_error in every build (tied low without STP_RX_PARITY_EN).
interface stp_rx_ctrl_if;
  import stp_rx_pkg::*;

  logic                     serial_in;
  logic [NUM_DATA_BITS-1:0] parallel_in;
  logic                     data_read;
  logic                     shift_enable;
  logic [NUM_DATA_BITS-1:0] rx_data;
  logic                     data_ready;
  logic                     framing_error;
  logic                     overrun_error;
  logic                     parity_error;

  modport master (
    output serial_in, parallel_in, data_read,
    input  shift_enable, rx_data, data_ready,
    input  framing_error, overrun_error, parity_error
  );

  modport slave (
    input  serial_in, parallel_in, data_read,
    output shift_enable, rx_data, data_ready,
    output framing_error, overrun_error, parity_error
  );

endinterface

// File: rtl/stp_rx_timer.sv
// Bit timer: counts while enabled, wraps to 0 at the programmable value.
// rollover marks the wrap cycle.
module stp_rx_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] wrap,
  output logic         rollover
);

  logic [W-1:0] count;

  assign rollover = enable && (count == wrap);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (rollover)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/stp_rx_ctrl.sv
// Receive controller for an external 4-bit serial-to-parallel shifter.
// Parity bit checking is built only when STP_RX_PARITY_EN is defined.
module stp_rx_ctrl
  import stp_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         rst,
  stp_rx_ctrl_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST = 3'(NUM_DATA_BITS - 1);

  rx_state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tmr_wrap;
  logic tmr_clr, tmr_en, tmr_roll;
  logic shift, start_ok, load, frame_err;
  logic [NUM_DATA_BITS-1:0] rx_data_q;
  logic ready_q, fe_q, oe_q;
`ifdef STP_RX_PARITY_EN
  logic par_acc, par_bad, pe_q;
`endif

  stp_rx_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clr),
    .enable   (tmr_en),
    .wrap     (tmr_wrap),
    .rollover (tmr_roll)
  );

  always_comb begin
    state_nx  = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_wrap  = FULL;
    shift     = 1'b0;
    start_ok  = 1'b0;
    load      = 1'b0;
    frame_err = 1'b0;
`ifdef STP_RX_PARITY_EN
    par_bad   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (!bus.serial_in) state_nx = START_CHK;
      end
      // Half-bit wait so every later sample lands mid-bit
      START_CHK: begin
        tmr_en   = 1'b1;
        tmr_wrap = HALF;
        if (tmr_roll) begin
          if (!bus.serial_in) begin
            state_nx = DATA;
            start_ok = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        tmr_en = 1'b1;
        if (tmr_roll) begin
          shift = 1'b1;
          if (bit_cnt == LAST)
`ifdef STP_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
        end
      end
`ifdef STP_RX_PARITY_EN
      PARITY: begin
        tmr_en = 1'b1;
        if (tmr_roll) begin
          par_bad  = par_acc ^ bus.serial_in;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        tmr_en = 1'b1;
        if (tmr_roll) begin
          if (bus.serial_in)
`ifdef STP_RX_PARITY_EN
            state_nx = pe_q ? IDLE : LOAD;
`else
            state_nx = LOAD;
`endif
          else begin
            frame_err = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      LOAD: begin
        tmr_clr  = 1'b1;
        load     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
`ifdef STP_RX_PARITY_EN
      par_acc   <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (start_ok) begin
        bit_cnt <= '0;
        fe_q    <= 1'b0;
`ifdef STP_RX_PARITY_EN
        par_acc <= 1'b0;
        pe_q    <= 1'b0;
`endif
      end else if (shift) begin
        bit_cnt <= bit_cnt + 3'd1;
`ifdef STP_RX_PARITY_EN
        par_acc <= par_acc ^ bus.serial_in;
`endif
      end
      if (frame_err) fe_q <= 1'b1;
`ifdef STP_RX_PARITY_EN
      if (par_bad) pe_q <= 1'b1;
`endif
      if (load) begin
        rx_data_q <= bus.parallel_in;
        ready_q   <= 1'b1;
      end else if (bus.data_read) begin
        ready_q   <= 1'b0;
      end
      // A read in the load cycle consumes the old word, so no overrun
      if (load && ready_q && !bus.data_read)
        oe_q <= 1'b1;
      else if (bus.data_read)
        oe_q <= 1'b0;
    end
  end

  assign bus.shift_enable  = shift;
  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = ready_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = oe_q;
`ifdef STP_RX_PARITY_EN
  assign bus.parity_error  = pe_q;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Directed bench for stp_rx_ctrl at CLKS_PER_BIT=10 with a shifter model.
// Parity frames are exercised when STP_RX_PARITY_EN is defined.
module tb_stp_rx_ctrl;
  import stp_rx_pkg::*;

`ifdef STP_RX_PARITY_EN
  localparam int FB = 7;
`else
  localparam int FB = 6;
`endif
  localparam int LOAD_K = FB * 10 - 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] sr = 4'h0;
  int vecs = 0;
  int miss = 0;
  int n;

  always #5 clk = ~clk;

  stp_rx_ctrl_if bus ();

  stp_rx_ctrl #(.CLKS_PER_BIT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.parallel_in = sr;

  always @(posedge clk)
    if (bus.shift_enable) sr <= {bus.serial_in, sr[3:1]};

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string t, input logic [3:0] rx,
                      input logic dr, input logic fe,
                      input logic oe, input logic pe);
    chk({t, "_rx"}, 8'(bus.rx_data), 8'(rx));
    chk({t, "_dr"}, 8'(bus.data_ready), 8'(dr));
    chk({t, "_fe"}, 8'(bus.framing_error), 8'(fe));
    chk({t, "_oe"}, 8'(bus.overrun_error), 8'(oe));
    chk({t, "_pe"}, 8'(bus.parity_error), 8'(pe));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk(input logic [3:0] d, input logic stp);
`ifdef STP_RX_PARITY_EN
    return {1'b1, stp, ^d, d, 1'b0};
`else
    return {2'b11, stp, d, 1'b0};
`endif
  endfunction

  task automatic send_frame(input logic [7:0] bits, input int rd_at);
    int bad = 0;
    int cnt = 0;
    for (int k = 0; k < FB * 10; k++) begin
      bus.serial_in = bits[k / 10];
      bus.data_read = (k == rd_at);
      @(negedge clk);
      if (bus.shift_enable === 1'b1) cnt++;
      if (bus.shift_enable !== (k % 10 == 5 && k >= 15 && k <= 45))
        bad++;
      tick;
    end
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (10) tick;
    chk("shift_pos", 8'(bad), 8'd0);
    chk("shift_cnt", 8'(cnt), 8'd4);
  endtask

  task automatic read_pulse;
    bus.data_read = 1'b1;
    tick;
    bus.data_read = 1'b0;
    tick;
  endtask

  initial begin
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    rst = 1'b1;
    repeat (2) tick;
    outs("reset", 4'h0, 0, 0, 0, 0);
    chk("reset_shift", 8'(bus.shift_enable), 8'd0);

    rst = 1'b0;
    send_frame(mk(4'hD, 1'b1), -1);
    outs("frame_d", 4'hD, 1, 0, 0, 0);

    read_pulse;
    outs("read", 4'hD, 0, 0, 0, 0);

    n = 0;
    bus.serial_in = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) bus.serial_in = 1'b1;
      @(negedge clk);
      if (bus.shift_enable === 1'b1) n++;
      tick;
    end
    chk("glitch_shift", 8'(n), 8'd0);
    outs("glitch", 4'hD, 0, 0, 0, 0);

    send_frame(mk(4'h6, 1'b0), -1);
    outs("framing", 4'hD, 0, 1, 0, 0);

    send_frame(mk(4'hA, 1'b1), -1);
    outs("refrm", 4'hA, 1, 0, 0, 0);

    send_frame(mk(4'h5, 1'b1), -1);
    outs("overrun", 4'h5, 1, 0, 1, 0);

    read_pulse;
    outs("ovr_clr", 4'h5, 0, 0, 0, 0);

    send_frame(mk(4'hA, 1'b1), -1);
    outs("a_again", 4'hA, 1, 0, 0, 0);
    send_frame(mk(4'h5, 1'b1), LOAD_K);
    outs("rd_load", 4'h5, 1, 0, 0, 0);

    bus.serial_in = 1'b0;
    repeat (20) tick;
    bus.serial_in = 1'b1;
    rst = 1'b1;
    tick;
    outs("rst_mid", 4'h0, 0, 0, 0, 0);
    chk("rst_mid_shift", 8'(bus.shift_enable), 8'd0);
    tick;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.shift_enable === 1'b1) n++;
      tick;
    end
    chk("post_rst_shift", 8'(n), 8'd0);

`ifdef STP_RX_PARITY_EN
    send_frame({1'b1, 1'b1, 1'b0, 4'hD, 1'b0}, -1);
    outs("par_bad", 4'h0, 0, 0, 0, 1);
    send_frame({1'b1, 1'b1, 1'b1, 4'hD, 1'b0}, -1);
    outs("par_ok", 4'hD, 1, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/stp_rx_ctrl.md
STP_RX_CTRL -- requirements
Module: stp_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit (legal range 4..255, even).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port serial_in, input, 1, the serial line (idle high), already synchronous to clk.
REQ-005 SHALL have port parallel_in, input, 4, the parallel_out of the attached 4-bit serial-to-parallel shifter.
REQ-006 SHALL have port data_read, input, 1, a consumer acknowledge that clears data_ready.
REQ-007 SHALL have port shift_enable, output, 1, a one-cycle shift strobe to the shifter.
REQ-008 SHALL have port rx_data, output, 4, the last accepted frame.
REQ-009 SHALL have port data_ready, output, 1, high while rx_data is valid and unread.
REQ-010 SHALL have ports framing_error, overrun_error and parity_error, each output, 1, the error flags.

Function
REQ-011 SHALL implement FSM states IDLE, START_CHK, DATA, PARITY, STOP and LOAD.
REQ-012 IDLE: serial_in==0 SHALL move the FSM to START_CHK and clear the bit timer.
REQ-013 START_CHK: at timer==CLKS_PER_BIT/2-1, serial_in==0 SHALL move to DATA, clear the timer and clear framing_error and parity_error; serial_in==1 SHALL return to IDLE (glitch) with no other effect.
REQ-014 DATA: shift_enable SHALL be 1 for exactly the cycle in which timer==CLKS_PER_BIT-1, with the timer wrapping to 0 and bit_cnt incrementing in that cycle.
REQ-015 After the 4th shift, the FSM SHALL move to PARITY if STP_RX_PARITY_EN is defined, else to STOP.
REQ-016 STOP: at timer==CLKS_PER_BIT-1, serial_in==1 SHALL move to LOAD; serial_in==0 SHALL set framing_error and move to IDLE with no load.
REQ-017 LOAD: lasting one cycle, rx_data SHALL capture parallel_in, data_ready SHALL be set, and the FSM SHALL move to IDLE.
REQ-018 If data_ready is already 1 and data_read is 0 in the LOAD cycle, overrun_error SHALL be set and rx_data overwritten; overrun_error SHALL clear only on a data_read pulse.
REQ-019 data_read SHALL clear data_ready on the next edge; data_read and LOAD in the same cycle SHALL leave data_ready=1 with no overrun.
REQ-020 shift_enable SHALL never assert outside DATA; the first shift SHALL occur 1.5 bit periods after the start edge was sampled (mid-bit sampling).
REQ-021 The bit timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, and bit_cnt SHALL be 3 bits, saturating never (it is cleared on entry to DATA).

Reset
REQ-022 rst==1 at an edge SHALL force IDLE, timer=0, bit_cnt=0, shift_enable=0, rx_data=4'h0, data_ready=0 and all error flags 0, including mid-frame.
REQ-023 The first start bit SHALL be recognized when serial_in==0 is sampled in the first edge after rst deasserts.

Configuration
REQ-024 Macro STP_RX_PARITY_EN defined: PARITY state SHALL sample serial_in at timer==CLKS_PER_BIT-1, checking even parity over the 4 data bits plus the parity bit (running XOR captured at each shift_enable).
REQ-025 On a parity mismatch, parity_error SHALL be set and the FSM SHALL proceed to STOP, while LOAD SHALL be suppressed (frame discarded).
REQ-026 Macro STP_RX_PARITY_EN undefined: no PARITY state or XOR logic SHALL exist, and parity_error SHALL be tied to 0 with the port retained.

Structure
REQ-027 Package stp_rx_pkg SHALL hold the state enum type rx_state_t, NUM_DATA_BITS=4 and DEFAULT_CLKS_PER_BIT=10.
REQ-028 Sub-module stp_rx_timer (clear, enable, programmable wrap value, rollover flag) SHALL implement the bit timer; the FSM SHALL stay in stp_rx_ctrl.

Verification
REQ-029 Reset: rst=1 for 2 cycles mid-DATA -> all outputs 0 at the next edge, and no shift_enable afterwards until a new start bit.
REQ-030 Frame start 0, data 1,0,1,1, stop 1 with CLKS_PER_BIT=10 -> 4 shift_enable pulses at cycles 15/25/35/45 after the start sample; LOAD copies parallel_in (4'b1101 from the shifter model); data_ready=1.
REQ-031 serial_in low for 3 cycles only -> no shift_enable, FSM back in IDLE, outputs unchanged.
REQ-032 Valid data with stop bit 0 -> framing_error=1, data_ready and rx_data unchanged; the next valid start clears framing_error.
REQ-033 Two valid frames 4'hA then 4'h5 with no data_read -> overrun_error=1 and rx_data=4'h5; data_read in the second LOAD cycle -> overrun_error stays 0.
REQ-034 With STP_RX_PARITY_EN: data 1,0,1,1 with parity 0 -> parity_error=1 and no load; with parity 1 -> clean load.
